// File: rtl/uart_tx_module.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// All outputs are registered; Tx idles high.
module uart_tx_module #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1,
    localparam int BW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          Tx,
    output logic          busy,
    output logic          frame_done,
    output logic [CW-1:0] fifo_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            bit_end;
    logic [7:0]      head;

    assign head    = mem_q[rptr_q];
    assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    // FIFO bookkeeping: pop only on the IDLE->START transition
    always_comb begin
        push    = tx_valid & ready_q;
        pop     = (state_q == S_IDLE) && (count_q != '0);
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    // FIFO storage; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= tx_data;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Next-state: bit timing, bit index and shift register
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    shift_d = head;
                    par_d   = (^head) ^ (PARITY_ODD != 0);
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs registered from next-state so Tx moves with the state
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_d == S_STOP)
              && (baud_d == BW'(CLKS_PER_BIT - 1))
              && (bit_d == 3'(STOP_BITS - 1));
        busy_d = (state_d != S_IDLE) || (count_d != '0);
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign Tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign tx_ready   = ready_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module with four parameter variants.
// Each serial level is checked on every clock of the frame.
module tb_uart_tx_module;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] d   [4];
    logic       v   [4];
    logic       rdy [4];
    logic       txo [4];
    logic       bsy [4];
    logic       dn  [4];
    logic [2:0] cnt [4];

    int vecs = 0;
    int errs = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_module #(.CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .Tx(txo[0]), .busy(bsy[0]),
        .frame_done(dn[0]), .fifo_count(cnt[0]));

    uart_tx_module #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .Tx(txo[1]), .busy(bsy[1]),
        .frame_done(dn[1]), .fifo_count(cnt[1]));

    uart_tx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u2 (
        .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .Tx(txo[2]), .busy(bsy[2]),
        .frame_done(dn[2]), .fifo_count(cnt[2]));

    uart_tx_module #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(v[3]),
        .tx_ready(rdy[3]), .Tx(txo[3]), .busy(bsy[3]),
        .frame_done(dn[3]), .fifo_count(cnt[3]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Enqueue one byte; Tx must still be high the cycle after acceptance
    task automatic send(input int k, input logic [7:0] b);
        d[k] = b;
        v[k] = 1'b1;
        @(negedge clk);
        v[k] = 1'b0;
        chk($sformatf("u%0d lat %0h", k, b), 32'(txo[k]), 32'd1);
    endtask

    // Caller sits on the negedge of clock index 'first' of the frame
    task automatic frame(input int k, input logic [7:0] b, input int pen,
                         input logic pbit, input int nstop, input int first);
        logic [11:0] lvl;
        int          nb;
        nb  = 9 + pen + nstop;
        lvl = '1;
        lvl[0] = 1'b0;
        for (int j = 0; j < 8; j++) lvl[j+1] = b[j];
        if (pen != 0) lvl[9] = pbit;
        for (int i = first; i < nb * CPB; i++) begin
            if (i > first) @(negedge clk);
            chk($sformatf("u%0d tx %0h i%0d", k, b, i),
                32'(txo[k]), 32'(lvl[i / CPB]));
            chk($sformatf("u%0d done %0h i%0d", k, b, i),
                32'(dn[k]), 32'(i == nb * CPB - 1));
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d[k] = '0;
            v[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst tx", 32'(txo[0]), 32'd1);
        chk("rst ready", 32'(rdy[0]), 32'd1);
        chk("rst busy", 32'(bsy[0]), 32'd0);
        chk("rst done", 32'(dn[0]), 32'd0);
        chk("rst count", 32'(cnt[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 0xA5, even parity 0
        send(0, 8'hA5);
        @(negedge clk);
        chk("a5 busy", 32'(bsy[0]), 32'd1);
        frame(0, 8'hA5, 1, 1'b0, 1, 0);
        @(negedge clk);
        chk("a5 idle busy", 32'(bsy[0]), 32'd0);
        chk("a5 idle tx", 32'(txo[0]), 32'd1);

        // odd parity of 0x00 -> 1
        send(1, 8'h00);
        @(negedge clk);
        frame(1, 8'h00, 1, 1'b1, 1, 0);

        // no parity, 0xFF, 40 clocks
        send(2, 8'hFF);
        @(negedge clk);
        frame(2, 8'hFF, 0, 1'b0, 1, 0);

        // two stop bits, 0x5A even parity 0
        send(3, 8'h5A);
        @(negedge clk);
        frame(3, 8'h5A, 1, 1'b0, 2, 0);
        @(negedge clk);

        // FIFO fill: five writes, sixth ignored
        for (int j = 0; j < 5; j++) begin
            d[0] = 8'(j + 1);
            v[0] = 1'b1;
            @(negedge clk);
            if (j == 1) chk("fill start", 32'(txo[0]), 32'd0);
        end
        chk("fill ready", 32'(rdy[0]), 32'd0);
        chk("fill count", 32'(cnt[0]), 32'd4);
        d[0] = 8'h06;
        @(negedge clk);
        v[0] = 1'b0;
        chk("full ready", 32'(rdy[0]), 32'd0);
        chk("full count", 32'(cnt[0]), 32'd4);
        frame(0, 8'h01, 1, 1'b1, 1, 4);
        @(negedge clk);
        chk("gap2", 32'(txo[0]), 32'd1);
        @(negedge clk);
        frame(0, 8'h02, 1, 1'b1, 1, 0);
        @(negedge clk);
        chk("gap3", 32'(txo[0]), 32'd1);
        @(negedge clk);
        frame(0, 8'h03, 1, 1'b0, 1, 0);
        @(negedge clk);
        chk("gap4", 32'(txo[0]), 32'd1);
        @(negedge clk);
        frame(0, 8'h04, 1, 1'b1, 1, 0);
        @(negedge clk);
        chk("gap5", 32'(txo[0]), 32'd1);
        @(negedge clk);
        frame(0, 8'h05, 1, 1'b0, 1, 0);
        @(negedge clk);
        chk("drain busy", 32'(bsy[0]), 32'd0);
        chk("drain count", 32'(cnt[0]), 32'd0);
        chk("drain tx", 32'(txo[0]), 32'd1);

        // simultaneous push and pop
        send(0, 8'hC3);
        @(negedge clk);
        d[0] = 8'h07;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        chk("pp count1", 32'(cnt[0]), 32'd1);
        frame(0, 8'hC3, 1, 1'b0, 1, 1);
        @(negedge clk);
        chk("pp idle tx", 32'(txo[0]), 32'd1);
        chk("pp idle count", 32'(cnt[0]), 32'd1);
        d[0] = 8'h42;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        chk("pp count", 32'(cnt[0]), 32'd1);
        frame(0, 8'h07, 1, 1'b1, 1, 0);
        @(negedge clk);
        chk("pp gap", 32'(txo[0]), 32'd1);
        @(negedge clk);
        frame(0, 8'h42, 1, 1'b0, 1, 0);
        @(negedge clk);

        // reset during data bit 3
        send(0, 8'h91);
        @(negedge clk);
        d[0] = 8'h55;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid tx", 32'(txo[0]), 32'd0);
        chk("mid count", 32'(cnt[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst tx", 32'(txo[0]), 32'd1);
        chk("arst busy", 32'(bsy[0]), 32'd0);
        chk("arst count", 32'(cnt[0]), 32'd0);
        chk("arst ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(0, 8'h3C);
        @(negedge clk);
        frame(0, 8'h3C, 1, 1'b0, 1, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("post tx %0d", j), 32'(txo[0]), 32'd1);
            chk($sformatf("post busy %0d", j), 32'(bsy[0]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
Serial transmitter for the board's UART link, the outbound counterpart of the receive path that feeds the address decoder. Buffers bytes from the register/debug logic in a small FIFO and shifts each one out on Tx as start bit, 8 data bits LSB first, optional parity bit, and stop bit(s). It runs on the single system clock, with an internal bit-period counter.

Parameters:
CLKS_PER_BIT, 868, system clocks per serial bit (100 MHz / 115200 baud); minimum 2
PARITY_EN, 1, 1 = insert parity bit after data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 4, byte FIFO depth, power of two, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
tx_data  in  8  byte to enqueue
tx_valid  in  1  enqueue request; byte accepted in a cycle when tx_valid=1 and tx_ready=1
tx_ready  out  1  FIFO not full
Tx  out  1  serial line, idle high
busy  out  1  high while a frame is on the line or the FIFO is non-empty
frame_done  out  1  one-cycle pulse at the end of the last stop bit
fifo_count  out  log2(FIFO_DEPTH)+1  bytes currently in the FIFO, excluding the byte being shifted

Behaviour:
- Reset (rst=0, asynchronous):
  - Tx=1, tx_ready=1, busy=0, frame_done=0, fifo_count=0.
  - FSM goes to IDLE; bit counter, baud counter and FIFO pointers clear.
  - A frame in progress is abandoned immediately; Tx returns high with no stop bit.
- FIFO:
  - Write on tx_valid & tx_ready. Writes while full are ignored; tx_ready=0 prevents them.
  - Read (pop) happens only on the IDLE->START transition.
  - Simultaneous write and pop in one cycle: both succeed and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_ready is registered and reflects the occupancy after that cycle's updates.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. If the FIFO is non-empty, pop the head byte into the shift register, compute parity (XOR of 8 bits, inverted if PARITY_ODD), clear the baud counter, go to START.
    - Latency: a byte written into an empty FIFO in cycle N is popped in cycle N+1; Tx falls in cycle N+2.
  - START: Tx=0 for CLKS_PER_BIT clocks, then DATA with bit index 0.
  - DATA: Tx=shift[0] for CLKS_PER_BIT clocks per bit; shift right after each bit.
    - After bit 7: go to PARITY if PARITY_EN, else STOP.
  - PARITY: Tx=parity bit for CLKS_PER_BIT clocks, then STOP.
  - STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT clocks.
    - frame_done pulses in the final clock of the last stop bit.
    - Next state is IDLE.
- Back-to-back frames: when the FIFO is non-empty at frame end, IDLE lasts exactly one clock before the next START. This gives an inter-frame gap of 1 clock beyond the stop bits.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clocks, from Tx falling to frame_done inclusive. Every bit is exactly CLKS_PER_BIT clocks wide.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and is reset at each bit boundary. It never free-runs in IDLE.
- The byte under transmission is held in the shift register, so FIFO writes during a frame never corrupt it.
- busy = (state != IDLE) | (fifo_count != 0), registered.
- Tx is driven from a register; there is no combinational path from tx_data or tx_valid to Tx.

Test Plan:
- Single byte, defaults with CLKS_PER_BIT=4 → write 0xA5. Expect Tx = 0,1,0,1,0,0,1,0,1,0(parity even),1, each level 4 clocks wide; frame_done once, 44 clocks after Tx falls; busy low afterwards.
- PARITY_ODD=1, byte 0x00 → parity bit 1. PARITY_EN=0 with byte 0xFF → 10-bit frame of 40 clocks, no parity slot.
- FIFO fill: 5 consecutive writes (0x01..0x05) while idle, depth 4.
  - First byte pops immediately and the next 4 fill the FIFO, so tx_ready drops after the 5th write; a 6th write attempt is ignored.
  - All 5 bytes appear on Tx in order, separated by exactly 1 idle clock.
- Simultaneous push/pop: FIFO holds 1 byte and a write lands in the same cycle as the IDLE->START pop → fifo_count stays 1, and both bytes are transmitted in order.
- Reset mid-frame: assert rst=0 during DATA bit 3 → Tx=1, busy=0 and fifo_count=0 immediately (asynchronous). After release, a new write of 0x3C transmits correctly with no remnant of the old frame.
- STOP_BITS=2, CLKS_PER_BIT=4 → stop phase lasts 8 clocks and frame_done is asserted only on its last clock.
